// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg
// Shared constants for the write-back stage.
//   RST_ENABLE : active level of the synchronous reset
//   load_op_e  : data-memory load type codes carried down the pipeline
//                (5..7 are reserved and treated as misaligned loads)
package wb_stage_pkg;

  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic [2:0] {
    LOAD_LB  = 3'd0,
    LOAD_LBU = 3'd1,
    LOAD_LH  = 3'd2,
    LOAD_LHU = 3'd3,
    LOAD_LW  = 3'd4
  } load_op_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align
// Purely combinational big-endian load alignment and extension.
//   word       : raw data-memory read word
//   op         : load type (load_op_e encoding)
//   byte_addr  : low two address bits of the load
//   data       : aligned and sign/zero-extended result
//   misaligned : access cannot be performed (bad alignment or reserved op)
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        op,
  input  logic [1:0]        byte_addr,
  output logic [DATA_W-1:0] data,
  output logic              misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Big-endian lane select: address 0 is the most significant byte/half.
  always_comb begin
    sel_byte = word[DATA_W-1 -: 8];
    case (byte_addr)
      2'd0: sel_byte = word[DATA_W-1  -: 8];
      2'd1: sel_byte = word[DATA_W-9  -: 8];
      2'd2: sel_byte = word[DATA_W-17 -: 8];
      2'd3: sel_byte = word[DATA_W-25 -: 8];
      default: sel_byte = word[DATA_W-1 -: 8];
    endcase
    sel_half = byte_addr[1] ? word[DATA_W-17 -: 16] : word[DATA_W-1 -: 16];
  end

  // Extension per load type. Reserved encodings are flagged so the
  // stage suppresses the write instead of committing garbage.
  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    case (op)
      LOAD_LB:  data = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
      LOAD_LBU: data = {{(DATA_W-8){1'b0}}, sel_byte};
      LOAD_LH: begin
        data       = {{(DATA_W-16){sel_half[15]}}, sel_half};
        misaligned = byte_addr[0];
      end
      LOAD_LHU: begin
        data       = {{(DATA_W-16){1'b0}}, sel_half};
        misaligned = byte_addr[0];
      end
      LOAD_LW: begin
        data       = word;
        misaligned = (byte_addr != 2'd0);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage
// MEM/WB pipeline register and register-file write-back driver.
//   clk, rst            : clock, synchronous active-high reset
//   mem_wreg/wd/wdata   : MEM-stage write request, destination, ALU result
//   mem_load/load_op    : load indicator and load type
//   mem_byte_addr       : low address bits of the load
//   dmem_rdata          : synchronous data-memory word (valid in first WB cycle)
//   stall_mem/stall_wb  : controller stall bits for MEM and WB
//   flush               : pipeline flush
//   we/waddr/wdata      : register file write port (combinational)
//   misalign            : one-cycle pulse when a misaligned load is dropped
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_load,
  input  logic [2:0]        mem_load_op,
  input  logic [1:0]        mem_byte_addr,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              misalign
);

  logic              wreg_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              load_q;
  logic [2:0]        op_q;
  logic [1:0]        ba_q;
  logic              first_q;
  logic [DATA_W-1:0] hold_q;

  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] align_data;
  logic              align_bad;
  logic              bad_load;

  // The memory word is only on dmem_rdata during the first WB cycle, so
  // hold_q snapshots it when that cycle is about to be held. first_q tells
  // whether the entry is in its first WB cycle.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wreg_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      op_q    <= '0;
      ba_q    <= '0;
      first_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      if (first_q && stall_wb) begin
        hold_q <= dmem_rdata;
      end
      if (flush || (stall_mem && !stall_wb)) begin
        wreg_q  <= 1'b0;
        addr_q  <= '0;
        data_q  <= '0;
        load_q  <= 1'b0;
        op_q    <= '0;
        ba_q    <= '0;
        first_q <= 1'b0;
      end else if (stall_wb) begin
        first_q <= 1'b0;
      end else begin
        wreg_q  <= mem_wreg;
        addr_q  <= mem_wd;
        data_q  <= mem_wdata;
        load_q  <= mem_load;
        op_q    <= mem_load_op;
        ba_q    <= mem_byte_addr;
        first_q <= 1'b1;
      end
    end
  end

  assign load_word = first_q ? dmem_rdata : hold_q;

  load_align #(.DATA_W(DATA_W)) u_align (
    .word       (load_word),
    .op         (op_q),
    .byte_addr  (ba_q),
    .data       (align_data),
    .misaligned (align_bad)
  );

  // Write port is driven straight from the registered entry so the
  // register file bypass sees it in the same cycle.
  always_comb begin
    bad_load = load_q & align_bad;
    we       = wreg_q & ~bad_load;
    waddr    = addr_q;
    wdata    = load_q ? align_data : data_q;
    misalign = bad_load & first_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage
// Self-checking bench for wb_stage: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the write-back stage.
module tb_wb_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              mem_wreg;
  logic [ADDR_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_load;
  logic [2:0]        mem_load_op;
  logic [1:0]        mem_byte_addr;
  logic [DATA_W-1:0] dmem_rdata;
  logic              stall_mem;
  logic              stall_wb;
  logic              flush;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              misalign;

  int n_checks = 0;
  int n_pass   = 0;

  wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_wreg      (mem_wreg),
    .mem_wd        (mem_wd),
    .mem_wdata     (mem_wdata),
    .mem_load      (mem_load),
    .mem_load_op   (mem_load_op),
    .mem_byte_addr (mem_byte_addr),
    .dmem_rdata    (dmem_rdata),
    .stall_mem     (stall_mem),
    .stall_wb      (stall_wb),
    .flush         (flush),
    .we            (we),
    .waddr         (waddr),
    .wdata         (wdata),
    .misalign      (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
  endtask

  // Reference load semantics written as plain shifts on the word.
  function automatic logic [31:0] model_align(input logic [31:0] w, input logic [2:0] op,
                                              input logic [1:0] ba);
    logic [7:0]  b;
    logic [15:0] h;
    int          bs;
    int          hs;
    bs = 8 * (3 - int'(ba));
    hs = 16 * (1 - int'(ba[1]));
    b  = 8'((w >> bs) & 32'h0000_00FF);
    h  = 16'((w >> hs) & 32'h0000_FFFF);
    case (op)
      3'd0:    return 32'($signed(b));
      3'd1:    return {24'h0, b};
      3'd2:    return 32'($signed(h));
      3'd3:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic bit model_bad(input logic [2:0] op, input logic [1:0] ba);
    if (op > 3'd4) return 1'b1;
    if ((op == 3'd2 || op == 3'd3) && ba[0]) return 1'b1;
    if (op == 3'd4 && ba != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  // Model state: the instruction currently in WB and how many cycles it
  // has spent there (age 0 = first WB cycle, when memory data is live).
  bit          m_init = 1'b0;
  logic        m_wreg;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_load;
  logic [2:0]  m_op;
  logic [1:0]  m_ba;
  int          m_age;
  logic [31:0] m_word;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1;
      m_wreg = 0; m_addr = 0; m_data = 0; m_load = 0; m_op = 0; m_ba = 0;
      m_age  = 1; m_word = 0;
    end else if (flush || (stall_mem && !stall_wb)) begin
      m_wreg = 0; m_addr = 0; m_data = 0; m_load = 0; m_op = 0; m_ba = 0;
      m_age  = 1;
    end else if (stall_wb) begin
      if (m_age == 0) m_word = dmem_rdata;
      if (m_age < 2) m_age++;
    end else begin
      m_wreg = mem_wreg; m_addr = mem_wd; m_data = mem_wdata;
      m_load = mem_load; m_op = mem_load_op; m_ba = mem_byte_addr;
      m_age  = 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] src;
    bit          bad;
    if (m_init) begin
      src = (m_age == 0) ? dmem_rdata : m_word;
      bad = m_load && model_bad(m_op, m_ba);
      chk("model we", 32'(we), 32'(m_wreg && !bad));
      chk("model waddr", 32'(waddr), 32'(m_addr));
      if (!bad) chk("model wdata", wdata, m_load ? model_align(src, m_op, m_ba) : m_data);
      chk("model misalign", 32'(misalign), 32'(bad && m_age == 0));
    end
  end

  // Drives one cycle of MEM-stage inputs just after a rising edge.
  task automatic applyStimulus(input logic wr, input logic [4:0] wd, input logic [31:0] wdat,
                               input logic ld, input logic [2:0] op, input logic [1:0] ba,
                               input logic [31:0] dm, input logic sm, input logic sw,
                               input logic fl, input logic rs);
    @(posedge clk);
    #1;
    mem_wreg = wr; mem_wd = wd; mem_wdata = wdat; mem_load = ld;
    mem_load_op = op; mem_byte_addr = ba; dmem_rdata = dm;
    stall_mem = sm; stall_wb = sw; flush = fl; rst = rs;
  endtask

  task automatic idle(input logic [31:0] dm, input logic sw, input logic fl, input logic rs);
    applyStimulus(0, 0, 0, 0, 0, 0, dm, 0, sw, fl, rs);
  endtask

  task automatic checkOutput(input string name, input logic e_we, input logic [4:0] e_addr,
                             input logic [31:0] e_data, input logic e_mis, input bit chk_data);
    @(negedge clk);
    chk({name, " we"}, 32'(we), 32'(e_we));
    chk({name, " waddr"}, 32'(waddr), 32'(e_addr));
    if (chk_data) chk({name, " wdata"}, wdata, e_data);
    chk({name, " misalign"}, 32'(misalign), 32'(e_mis));
  endtask

  initial begin
    rst = 1; mem_wreg = 0; mem_wd = 0; mem_wdata = 0; mem_load = 0; mem_load_op = 0;
    mem_byte_addr = 0; dmem_rdata = 0; stall_mem = 0; stall_wb = 0; flush = 0;

    // Reset state
    idle(0, 0, 0, 1);
    idle(0, 0, 0, 0);
    checkOutput("reset", 0, 0, 32'h0, 0, 1);

    // ALU write followed by a bubble
    applyStimulus(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 9, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("alu", 1, 5, 32'h1234_5678, 0, 1);
    idle(0, 0, 0, 0);
    checkOutput("bubble", 0, 0, 32'h0, 0, 1);

    // LB / LBU extension
    applyStimulus(1, 3, 0, 1, 3'd0, 2'd1, 0, 0, 0, 0, 0);
    applyStimulus(1, 4, 0, 1, 3'd1, 2'd1, 32'h0080_0000, 0, 0, 0, 0);
    checkOutput("lb", 1, 3, 32'hFFFF_FF80, 0, 1);
    idle(32'h0080_0000, 0, 0, 0);
    checkOutput("lbu", 1, 4, 32'h0000_0080, 0, 1);

    // Held LH keeps its data after the memory word changes
    applyStimulus(1, 6, 0, 1, 3'd2, 2'd2, 0, 0, 0, 0, 0);
    idle(32'hAAAA_8001, 1, 0, 0);
    checkOutput("lh first", 1, 6, 32'hFFFF_8001, 0, 1);
    idle(0, 1, 0, 0);
    checkOutput("lh hold1", 1, 6, 32'hFFFF_8001, 0, 1);
    idle(0, 1, 0, 0);
    checkOutput("lh hold2", 1, 6, 32'hFFFF_8001, 0, 1);
    idle(0, 0, 0, 0);
    checkOutput("lh hold3", 1, 6, 32'hFFFF_8001, 0, 1);

    // Misaligned LW pulses misalign once across a held entry
    applyStimulus(1, 7, 0, 1, 3'd4, 2'd2, 0, 0, 0, 0, 0);
    idle(32'h1111_2222, 1, 0, 0);
    checkOutput("lw mis first", 0, 7, 32'h0, 1, 0);
    idle(32'h3333_4444, 1, 0, 0);
    checkOutput("lw mis hold1", 0, 7, 32'h0, 0, 0);
    idle(0, 0, 0, 0);
    checkOutput("lw mis hold2", 0, 7, 32'h0, 0, 0);

    // Flush beats stall_wb
    applyStimulus(1, 10, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 1, 1, 0);
    checkOutput("pre flush", 1, 10, 32'hCAFE_F00D, 0, 1);
    idle(0, 0, 0, 0);
    checkOutput("flushed", 0, 0, 32'h0, 0, 1);

    // Reset during a held load drops it
    applyStimulus(1, 12, 0, 1, 3'd4, 2'd0, 0, 0, 0, 0, 0);
    idle(32'h1357_2468, 1, 0, 0);
    checkOutput("lw first", 1, 12, 32'h1357_2468, 0, 1);
    idle(0, 1, 0, 1);
    checkOutput("lw held", 1, 12, 32'h1357_2468, 0, 1);
    idle(0, 1, 0, 0);
    checkOutput("rst hold", 0, 0, 32'h0, 0, 1);

    // Write to register 0 is not filtered here
    applyStimulus(1, 0, 32'h0000_0055, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    checkOutput("r0 write", 1, 0, 32'h0000_0055, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      applyStimulus(1'($urandom), 5'($urandom), $urandom, 1'($urandom), op, 2'($urandom),
                    $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 49) == 0));
    end
    idle(0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and write-back unit; the writer side of the register file write port (we/waddr/wdata).
- Latches the MEM-stage result and aligns/sign-extends synchronous data-memory read data for loads.
- Honours pipeline stall/flush from the controller.
- Drives the register file write port combinationally from its registered state, so the register file write-through bypass sees the value in the same cycle.

Parameters:
- DATA_W, 32, register/data width (RegBus).
- ADDR_W, 5, register address width (RegAddrBus).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (RstEnable = 1'b1)
- mem_wreg  in  1  MEM-stage instruction writes a register
- mem_wd  in  ADDR_W  destination register address
- mem_wdata  in  DATA_W  ALU/move result (non-load)
- mem_load  in  1  instruction is a load
- mem_load_op  in  3  load type: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW; 5-7 reserved
- mem_byte_addr  in  2  low address bits of the load
- dmem_rdata  in  DATA_W  data-memory read word; valid the cycle after the load leaves MEM
- stall_mem  in  1  MEM stage held (stall[4])
- stall_wb  in  1  WB stage held (stall[5])
- flush  in  1  pipeline flush
- we  out  1  register file write enable
- waddr  out  ADDR_W  register file write address
- wdata  out  DATA_W  register file write data
- misalign  out  1  one-cycle pulse: misaligned load suppressed

Behaviour:
- Reset (rst=1 at posedge): all pipeline registers, the hold register and the first flag clear. Outputs are we=0, waddr=0, wdata=0 and misalign=0.
- Update priority at each posedge: rst > flush > bubble > hold > advance.
  - flush=1: clear entry (wreg=0, addr=0, data=0, load=0).
  - Bubble: stall_mem=1 and stall_wb=0. Clear the entry.
  - Hold: stall_wb=1. Keep the entry.
  - Advance: stall_mem=0. Latch all mem_* inputs and set first=1.
- first flag: set on advance. Cleared on any cycle the entry stays in WB (hold) and on bubble/flush.
- Load data capture:
  - With first=1 and stall_wb=1, capture dmem_rdata into hold_q at that posedge.
  - Load source word = dmem_rdata when first=1, else hold_q.
  - A held load keeps the correct data for any hold length.
- Alignment is big-endian: byte_addr 0 selects bits 31:24, and byte_addr 3 selects bits 7:0.
  - LB/LBU: select byte; sign-extend for LB, zero-extend for LBU.
  - LH/LHU: byte_addr 0 selects 31:16, byte_addr 2 selects 15:0; sign-extend or zero-extend.
  - LW: the whole word.
- Misalignment: LH/LHU with byte_addr[0]=1, LW with byte_addr!=0, or a reserved op.
  - Force we=0.
  - misalign=1 only while first=1, so it pulses once per instruction.
- Outputs are combinational from the registered entry:
  - we = wreg & ~misaligned.
  - waddr = addr.
  - wdata = aligned load data if load, else registered data.
- Writes to address 0 pass through; the register file discards them.
- Latency: a result presented in MEM at cycle N appears on we/waddr/wdata in cycle N+1.
- Simultaneous flush and stall: flush wins.
- rst during a held load: the entry is dropped and no write occurs.

Decomposition:
- Shared defines header (existing): RstEnable, WriteEnable, ZeroWord, RegBus, RegAddrBus, Stop/NoStop.
- New defines for the load op codes: LOAD_LB, LOAD_LBU, LOAD_LH, LOAD_LHU, LOAD_LW.
- One natural sub-module, load_align: purely combinational. Inputs are word, op and byte_addr; outputs are data and misaligned. Reusable by a future LL/LWL path.

Test Plan:
1. ALU write: mem_wreg=1, mem_wd=5, mem_wdata=32'h1234_5678, no stall → next cycle we=1, waddr=5, wdata=32'h1234_5678; one cycle later we=0 if MEM presents a bubble.
2. LB sign-extension: op=LB, byte_addr=1, dmem_rdata=32'h00_80_00_00 → wdata=32'hFFFF_FF80. Same stimulus with LBU → 32'h0000_0080.
3. Held load: LH, byte_addr=2, dmem_rdata=32'hAAAA_8001 in the first WB cycle. Then stall_wb=1 for 3 cycles while dmem_rdata changes to 32'h0 → wdata stays 32'hFFFF_8001 through all held cycles.
4. Bubble: stall_mem=1, stall_wb=0 with mem_wreg=1 → next cycle we=0, waddr=0, wdata=0.
5. Misaligned LW: byte_addr=2, wreg=1 → we=0, misalign=1 for exactly one cycle even with stall_wb=1 held for 2 cycles.
6. flush asserted together with stall_wb=1 on a valid entry → entry cleared (we=0). rst=1 mid-hold → all outputs 0 next cycle.
